instr_mem_loader: RTL

Boot-time writer for the byte-organised instruction memory. Accepts a framed byte stream (length header, payload, checksum) over a valid/ready handshake and writes each payload byte to consecutive instruction-memory addresses, starting at 0. Holds the processor in reset until the image has been written and verified. Sits between the external download link and the instruction memory write port, and drives the processor's `nReset`.

---
 rtl/instr_mem_loader_if.sv | 22 ++
 rtl/instr_mem_loader.sv | 126 ++++++++++++
 2 files changed

// File: rtl/instr_mem_loader_if.sv
// rtl/instr_mem_loader_if.sv - download byte stream and instruction-memory write port
interface instr_mem_loader_if #(
    parameter int MEM_CELL_SIZE = 8,
    parameter int ADDR_W        = 8
);
    logic [MEM_CELL_SIZE-1:0] InByte;
    logic                     InValid;
    logic                     InReady;
    logic                     WrEn;
    logic [ADDR_W-1:0]        WrAddr;
    logic [MEM_CELL_SIZE-1:0] WrData;

    modport master (
        output InByte, InValid,
        input  InReady, WrEn, WrAddr, WrData
    );

    modport slave (
        input  InByte, InValid,
        output InReady, WrEn, WrAddr, WrData
    );
endinterface

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - boot loader writing a checksummed frame into instruction memory
module instr_mem_loader #(
    parameter int MEM_CELL_SIZE  = 8,
    parameter int INSTR_MEM_SIZE = 256,
    parameter int ADDR_W         = $clog2(INSTR_MEM_SIZE)
) (
    input  logic                Clock,
    input  logic                nReset,
    input  logic                Start,
    instr_mem_loader_if.slave   bus,
    output logic                CpuRun,
    output logic                Busy,
    output logic                Done,
    output logic                Error
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LENH  = 3'd1;
    localparam logic [2:0] LENL  = 3'd2;
    localparam logic [2:0] DATA  = 3'd3;
    localparam logic [2:0] CHECK = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;
    localparam logic [2:0] ERR   = 3'd6;

    localparam int              LW      = 2 * MEM_CELL_SIZE;
    localparam logic [LW-1:0]   MAX_LEN = LW'(INSTR_MEM_SIZE);

    logic [2:0]               state;
    logic [MEM_CELL_SIZE-1:0] len_hi;
    logic [ADDR_W:0]          len;
    logic [ADDR_W:0]          cnt;
    logic [7:0]               acc;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [MEM_CELL_SIZE-1:0] wr_data;

    logic                     in_ready;
    logic                     accept;
    logic [LW-1:0]            len_full;
    logic                     len_bad;
    logic [7:0]               acc_next;
    logic [ADDR_W:0]          cnt_next;

    // Ready is a pure state decode so the link never sees a path from InValid.
    assign in_ready = (state == LENH) || (state == LENL) || (state == DATA) || (state == CHECK);
    assign accept   = bus.InValid && in_ready;
    assign len_full = {len_hi, bus.InByte};
    assign len_bad  = (len_full == '0) || len_full[0] || (len_full > MAX_LEN);
    assign acc_next = acc + bus.InByte[7:0];
    assign cnt_next = cnt + 1'b1;

    assign bus.InReady = in_ready;
    assign bus.WrEn    = wr_en;
    assign bus.WrAddr  = wr_addr;
    assign bus.WrData  = wr_data;
    assign Busy        = in_ready;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state   <= IDLE;
            len_hi  <= '0;
            len     <= '0;
            cnt     <= '0;
            acc     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            CpuRun  <= 1'b0;
            Done    <= 1'b0;
            Error   <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (Start) begin
                        state  <= LENH;
                        cnt    <= '0;
                        acc    <= '0;
                        CpuRun <= 1'b0;
                        Done   <= 1'b0;
                        Error  <= 1'b0;
                    end
                end
                LENH: begin
                    if (accept) begin
                        len_hi <= bus.InByte;
                        state  <= LENL;
                    end
                end
                LENL: begin
                    if (accept) begin
                        if (len_bad) begin
                            state <= ERR;
                            Error <= 1'b1;
                        end else begin
                            len   <= len_full[ADDR_W:0];
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        wr_en   <= 1'b1;
                        wr_addr <= cnt[ADDR_W-1:0];
                        wr_data <= bus.InByte;
                        acc     <= acc_next;
                        cnt     <= cnt_next;
                        if (cnt_next == len) state <= CHECK;
                    end
                end
                CHECK: begin
                    if (accept) begin
                        if (acc_next == 8'd0) begin
                            state  <= DONE;
                            Done   <= 1'b1;
                            CpuRun <= 1'b1;
                        end else begin
                            state <= ERR;
                            Error <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
